// File: rtl/interrupter_gen.sv
// Multi-channel pulse generator with per-channel period/on-time, optional
// burst gating, a hard on-time ceiling and a shared latched fault that
// blanks every output until it is explicitly cleared.
module interrupter_gen #(
  parameter int CH_NUM = 2,
  parameter int CNT_W  = 24,
  parameter int MAX_ON = 4000,
  parameter int BST_W  = 8
) (
  input  logic                    i_clk,
  input  logic                    i_res_n,
  input  logic [CH_NUM-1:0]       i_en,
  input  logic [CH_NUM-1:0]       i_burst_mode,
  input  logic [CH_NUM*CNT_W-1:0] i_period,
  input  logic [CH_NUM*CNT_W-1:0] i_ontime,
  input  logic [CH_NUM*BST_W-1:0] i_burst_on,
  input  logic [CH_NUM*BST_W-1:0] i_burst_off,
  input  logic                    i_flt,
  input  logic                    i_flt_clr,
  output logic [CH_NUM-1:0]       o_pls,
  output logic [CH_NUM-1:0]       o_tick,
  output logic                    o_flt
);

  typedef enum logic {BURST_ON = 1'b0, BURST_OFF = 1'b1} bst_t;

  // Degenerate configs run with a period of 2 so the tick keeps going.
  function automatic logic [CNT_W-1:0] per_f(input logic [CNT_W-1:0] per,
                                             input logic [CNT_W-1:0] on);
    return (per < CNT_W'(2) || on == '0) ? CNT_W'(2) : per;
  endfunction

  // On-time clamp: min(ontime, period-1, MAX_ON); zero when degenerate.
  function automatic logic [CNT_W-1:0] eff_on_f(input logic [CNT_W-1:0] per,
                                                input logic [CNT_W-1:0] on);
    logic [CNT_W-1:0] lim;
    if (per < CNT_W'(2) || on == '0) return '0;
    lim = per - CNT_W'(1);
    if (CNT_W'(MAX_ON) < lim) lim = CNT_W'(MAX_ON);
    return (on < lim) ? on : lim;
  endfunction

  logic flt_nxt;

  // Set dominates clear; the next fault value also gates the channels so that
  // outputs drop on the same edge that latches the fault.
  always_comb flt_nxt = i_flt | (o_flt & ~i_flt_clr);

  // Fault latch.
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) o_flt <= 1'b0;
    else          o_flt <= flt_nxt;
  end

  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    logic [CNT_W-1:0] period, ontime;
    logic [BST_W-1:0] bon, boff;
    logic             mode, active, wrap, load, gate;
    logic [CNT_W-1:0] cnt, cnt_nxt, per_s, per_nxt, eff_s, eff_nxt;
    logic [BST_W-1:0] bcnt, bcnt_nxt;
    logic [BST_W:0]   binc;
    bst_t             state, state_nxt;
    logic             run, mode_s, mode_nxt, pls, pls_nxt, tick, tick_nxt;

    assign period = i_period[k*CNT_W +: CNT_W];
    assign ontime = i_ontime[k*CNT_W +: CNT_W];
    assign bon    = i_burst_on[k*BST_W +: BST_W];
    assign boff   = i_burst_off[k*BST_W +: BST_W];
    assign mode   = i_burst_mode[k];
    assign active = i_en[k] & ~flt_nxt;
    assign wrap   = (cnt == per_s - CNT_W'(1));
    assign load   = active & (~run | wrap);
    assign binc   = {1'b0, bcnt} + (BST_W+1)'(1);
    assign o_pls[k]  = pls;
    assign o_tick[k] = tick;

    // State register: counters, burst FSM, shadow config and outputs.
    always_ff @(posedge i_clk or negedge i_res_n) begin
      if (!i_res_n) begin
        cnt    <= '0;
        bcnt   <= '0;
        state  <= BURST_ON;
        per_s  <= '0;
        eff_s  <= '0;
        mode_s <= 1'b0;
        run    <= 1'b0;
        pls    <= 1'b0;
        tick   <= 1'b0;
      end else begin
        cnt    <= cnt_nxt;
        bcnt   <= bcnt_nxt;
        state  <= state_nxt;
        per_s  <= per_nxt;
        eff_s  <= eff_nxt;
        mode_s <= mode_nxt;
        run    <= active;
        pls    <= pls_nxt;
        tick   <= tick_nxt;
      end
    end

    // Next-state: counter wrap, burst sequencing and config sampling at period start.
    always_comb begin
      cnt_nxt   = cnt + CNT_W'(1);
      bcnt_nxt  = bcnt;
      state_nxt = state;
      per_nxt   = per_s;
      eff_nxt   = eff_s;
      mode_nxt  = mode_s;
      gate      = 1'b0;
      if (!active || !run) begin
        cnt_nxt   = '0;
        bcnt_nxt  = '0;
        state_nxt = BURST_ON;
      end else if (wrap) begin
        cnt_nxt = '0;
        if (!mode || mode != mode_s || bon == '0) begin
          state_nxt = BURST_ON;
          bcnt_nxt  = '0;
        end else if (state == BURST_ON) begin
          if (binc >= {1'b0, bon}) begin
            bcnt_nxt  = '0;
            state_nxt = (boff == '0) ? BURST_ON : BURST_OFF;
          end else begin
            bcnt_nxt = binc[BST_W-1:0];
          end
        end else begin
          if (binc >= {1'b0, boff}) begin
            bcnt_nxt  = '0;
            state_nxt = BURST_ON;
          end else begin
            bcnt_nxt = binc[BST_W-1:0];
          end
        end
      end
      if (load) begin
        gate     = (state_nxt == BURST_ON) && (!mode || bon != '0);
        per_nxt  = per_f(period, ontime);
        eff_nxt  = gate ? eff_on_f(period, ontime) : '0;
        mode_nxt = mode;
      end
    end

    // Output decode: pulse while the next count is inside the on-window.
    always_comb begin
      tick_nxt = load;
      pls_nxt  = 1'b0;
      if (active) pls_nxt = load ? (eff_nxt != '0) : (cnt_nxt < eff_s);
    end
  end

endmodule

// File: doc/interrupter_gen.md
INTERRUPTER_GEN -- requirements
Module: interrupter_gen

Interface
REQ-001 The parameters SHALL be as follows, one per line: name, default, meaning.
- CH_NUM, 2, number of independent pulse channels.
- CNT_W, 24, width of the period/on-time counters and config fields.
- MAX_ON, 4000, absolute on-time limit in clocks (100 us at 40 MHz).
- BST_W, 8, width of the burst-count fields.
REQ-002 The ports SHALL be as follows, one per line: name, direction, width, meaning.
- i_clk, input, 1, 40 MHz master clock.
- i_res_n, input, 1, asynchronous active-low reset.
- i_en, input, CH_NUM, per-channel enable.
- i_burst_mode, input, CH_NUM, per channel: 1 = burst, 0 = continuous.
- i_period, input, CH_NUM*CNT_W, per-channel period in clocks; channel k occupies bits [k*CNT_W +: CNT_W].
- i_ontime, input, CH_NUM*CNT_W, per-channel high time in clocks.
- i_burst_on, input, CH_NUM*BST_W, periods with pulses per burst.
- i_burst_off, input, CH_NUM*BST_W, silent periods per burst.
- i_flt, input, 1, fault (e.g. SFP_TX_FLT), active high, already synchronous to i_clk.
- i_flt_clr, input, 1, one-cycle fault-latch clear.
- o_pls, output, CH_NUM, registered pulse outputs.
- o_tick, output, CH_NUM, one-cycle strobe at each period start.
- o_flt, output, 1, latched fault flag.

Function
REQ-003 The module SHALL use one clock, i_clk; reset SHALL be asynchronous, active low, on i_res_n.
REQ-004 Each channel SHALL own a CNT_W-bit period counter (cnt) and a BST_W-bit period counter (bcnt); the channels SHALL be fully independent apart from the fault.
REQ-005 Configuration SHALL be sampled into shadow registers only at period start (cnt = 0); changes mid-period SHALL have no effect until the next period.
REQ-006 Effective on-time SHALL be min(ontime, period-1, MAX_ON); the result is an unsigned compare, with no wrap.
REQ-007 If period < 2 or ontime = 0, the channel output SHALL stay low and the counter SHALL still run with period 2 so that o_tick keeps pulsing.
REQ-008 Counter: cnt SHALL increment each clock while enabled; at cnt = period-1 it SHALL wrap to 0.
REQ-009 o_tick SHALL be asserted in the cycle where cnt = 0.
REQ-010 o_pls SHALL be registered and high exactly when cnt is in the range 0 to eff_on-1.
- Latency from cnt to o_pls: 0 cycles relative to the registered cnt, i.e. both are updated on the same edge.
REQ-011 On an i_en rising edge, the next edge SHALL load cnt = 0, with o_pls high and o_tick high.
- First pulse width: exactly eff_on clocks.
REQ-012 When i_en is deasserted, o_pls and o_tick SHALL go low on the next edge (no pulse completion), and cnt and bcnt SHALL clear to 0.
REQ-013 Burst mode SHALL use a two-state FSM per channel, BURST_ON and BURST_OFF; the FSM enters BURST_ON on enable.
- bcnt SHALL increment at each period wrap.
- BURST_ON transitions to BURST_OFF, with bcnt cleared, after burst_on periods.
- BURST_OFF transitions to BURST_ON after burst_off periods.
- o_pls SHALL be suppressed in BURST_OFF; o_tick still pulses.
REQ-014 Burst edge cases:
- burst_on = 0: output SHALL stay low.
- burst_off = 0: behaviour SHALL be identical to continuous mode.
- Changing i_burst_mode: SHALL take effect at the next period start; the FSM re-enters BURST_ON.
REQ-015 In continuous mode the FSM SHALL be held in BURST_ON and bcnt SHALL be held at 0.
REQ-016 A cycle with i_flt = 1 SHALL set o_flt on the next edge; while o_flt = 1, all o_pls SHALL be forced low and all channels held as disabled (cnt = 0).
REQ-017 i_flt_clr SHALL clear o_flt only if i_flt = 0 in that cycle; if both are asserted, the set SHALL win.
- After clear, any channel with i_en = 1 SHALL restart as on an enable rising edge.
REQ-018 o_pls SHALL never be high for more than MAX_ON consecutive clocks under any input sequence.
REQ-019 o_pls SHALL never stay high across a period wrap.

Reset
REQ-020 During reset, o_pls, o_tick, o_flt, cnt, bcnt and all shadow registers SHALL be 0, and the FSM SHALL be in BURST_ON.
REQ-021 Reset asserted mid-pulse SHALL drive o_pls low asynchronously.
REQ-022 After reset release, a channel with i_en held at 1 SHALL start as on an enable rising edge at the first clock edge.

Verification
REQ-023 Continuous mode, period = 40000, ontime = 20000 (1 kHz, 50 %): SHALL give o_pls high 20000 clocks and low 20000 clocks, with o_tick every 40000 clocks.
REQ-024 Clamping: period = 1000, ontime = 5000 SHALL give high 999 clocks, low 1; period = 40000, ontime = 10000 SHALL give high 4000 (MAX_ON), low 36000.
REQ-025 Burst mode, period = 100, ontime = 10, burst_on = 3, burst_off = 2: SHALL give three 10-clock pulses, then 200 silent clocks, repeating; o_tick every 100 clocks.
REQ-026 Config change mid-period: ontime changed from 10 to 50 at cnt = 5 SHALL leave the current pulse at 10 clocks, with the next pulse 50 clocks.
REQ-027 Fault: i_flt pulsed at cnt = 3 of a 10-clock pulse SHALL drive o_pls low on the next edge and set o_flt = 1.
- i_flt_clr asserted together with i_flt: o_flt SHALL stay 1.
- A later i_flt_clr with i_flt = 0: o_flt SHALL be 0 and a full 10-clock pulse SHALL start on the next edge.
REQ-028 Disable, then asynchronous reset mid-pulse: o_pls SHALL go low on the next edge (disable) or immediately (reset), with no residual pulse on re-enable.
- Two channels with different periods (100 and 37) SHALL run without interaction.
